seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, handshaked shift-add multiplier for the calculator datapath. It replaces the fixed 4-bit combinational array multiplier in the multiply path. It accepts one operand pair per transaction and iterates one multiplier bit per clock. It adds operand width as a parameter, a run-time signed/unsigned mode, and valid/ready flow control on both sides.

## Interface
- `WIDTH`, default 4: operand width in bits; legal values are 2 to 32. The product is `2*WIDTH` bits.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter. This is a derived localparam and must not be overridden.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operand pair is presented.
- `in_ready`, out, 1: block can accept a pair. High only in IDLE.
- `a`, in, `WIDTH`: multiplicand.
- `b`, in, `WIDTH`: multiplier.
- `signed_mode`, in, 1: 1 treats `a` and `b` as two's complement; 0 treats them as unsigned. Sampled only at acceptance.
- `out_valid`, out, 1: `product` is valid. High only in DONE.
- `out_ready`, in, 1: consumer accepts the product.
- `product`, out, `2*WIDTH`: result. Exact, no truncation, in both modes.

## Operation
- State machine with three states: IDLE, CALC, DONE.
- IDLE → CALC when `in_valid & in_ready`. On that edge the block does the following:
  - It latches the magnitudes of `a` and `b`. In signed mode, a negative operand is two's-complement negated. The most negative value `-2^(WIDTH-1)` has magnitude `2^(WIDTH-1)`, which fits in `WIDTH` unsigned bits.
  - It latches `neg = signed_mode & (a[MSB] ^ b[MSB])`.
  - It clears the accumulator (`2*WIDTH` bits) and loads the counter with `WIDTH`.
- CALC runs one iteration per edge. If the multiplier LSB is 1, the multiplicand is added into the accumulator at the current shift position. The multiplier shifts right by 1, the multiplicand shifts left by 1, and the counter decrements.
- CALC → DONE on the edge where the counter reaches 0, which is the `WIDTH`-th CALC edge. On that same edge, `product` is loaded with `neg ? -acc : acc`, taken modulo `2^(2*WIDTH)`.
- DONE → IDLE on `out_ready`. `product` keeps its value after the handshake until the next DONE entry.
- `in_valid` in CALC or DONE is ignored. The operands are not captured and no queueing occurs.
- Arithmetic rules:
  - Unsigned product range is 0 to `(2^WIDTH-1)^2`.
  - Signed range is `-2^(2W-2)+2^(W-1)` to `2^(2W-2)`. Both ranges fit in `2*WIDTH` bits.
  - A zero operand still takes the full `WIDTH` iterations. There is no early termination.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `product` 0, accumulator and counter 0.
- Latency:
  - If acceptance occurs on edge E0, `out_valid` is high after edge E(`WIDTH`). That is `WIDTH` cycles of latency, fixed and data-independent.
  - With `out_ready` held high, throughput is one result per `WIDTH+2` cycles. Those cycles are 1 accept, `WIDTH-1` further CALC cycles, 1 DONE, and 1 IDLE.
- Backpressure: while `out_valid=1 & out_ready=0`, `product` and `out_valid` hold stable indefinitely.
- `in_ready` is a pure function of state. It has no combinational path from `in_valid` or `out_ready`.
- Reset takes priority over every transition.
  - `rst` asserted in CALC or DONE returns the block to IDLE on that edge and clears `product`.
  - The in-flight transaction is discarded and no `out_valid` pulse is produced.
- `rst` and `in_valid` in the same cycle: reset wins and the pair is not accepted.

## Structure
- Shared package `calc_pkg`, containing:
  - The state enum `mul_state_t {IDLE, CALC, DONE}`.
  - The default width constant `CALC_WIDTH = 4`, shared with the adder and subtractor paths.
- One sub-module, `nbit_adder #(N)`: a parametrised ripple-carry adder with carry-in and carry-out.
  - Instantiated once at width `2*WIDTH` for the accumulate step.
  - The final negation reuses the same adder type, with `~acc` plus carry-in of 1.
- Everything else (state, counters, shift registers) lives in `seq_multiplier` itself.

## Test plan
- Unsigned max: `WIDTH`=4, `signed_mode`=0, `a`=15, `b`=15 → `product`=0x00E1 (225). `out_valid` rises exactly 4 cycles after the acceptance edge.
- Signed corners: `WIDTH`=4, `signed_mode`=1.
  - `a`=0x8, `b`=0x8 (-8×-8) → 0x40.
  - `a`=0xD, `b`=0x5 (-3×5) → 0xF1 (-15).
  - `a`=0x8, `b`=0x7 → 0xC8 (-56).
- Backpressure and busy:
  - Hold `out_ready`=0 for 10 cycles in DONE. `product` and `out_valid` must stay stable and `in_ready` must stay 0.
  - Pulse `in_valid` with new operands during CALC. The result must be unaffected.
- Reset mid-operation: assert `rst` for 1 cycle on the second CALC cycle → next cycle shows IDLE, `in_ready`=1, `product`=0, and no `out_valid` pulse. A following 6×7 unsigned transaction returns 42.
- Wide instance: `WIDTH`=8.
  - Unsigned 255×255 → 0xFE01 with latency 8.
  - Signed 0x80×0x80 → 0x4000.
  - Back-to-back transactions with `out_ready`=1 → one result every 10 cycles.
- Zero operand: `WIDTH`=4, `a`=0, `b`=9 → `product`=0 with the full 4-cycle latency.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: default operand width and the
// multiplier sequencer states.
package calc_pkg;

    localparam int CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

endpackage

// File: rtl/nbit_adder.sv
// Parametrised ripple-carry adder with carry-in and carry-out.
module nbit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// Handshaked shift-add multiplier: one multiplier bit per clock, fixed WIDTH-cycle
// latency, signed or unsigned operands selected per transaction.
module seq_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    mul_state_t       state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    neg_sum;
    logic             acc_cout_unused;
    logic             neg_cout_unused;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign a_mag  = (signed_mode & a[WIDTH-1]) ? -a : a;
    assign b_mag  = (signed_mode & b[WIDTH-1]) ? -b : b;
    assign addend = mplier[0] ? mcand : '0;

    nbit_adder #(.N(PW)) u_acc_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (acc_next),
        .cout (acc_cout_unused)
    );

    // Two's-complement negate of the final accumulator: ~x + 1.
    nbit_adder #(.N(PW)) u_neg_add (
        .a    (~acc_next),
        .b    ({PW{1'b0}}),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_cout_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        state    <= CALC;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        product   <= neg ? neg_sum : acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a 4-bit and an 8-bit instance checked against a
// plain-arithmetic product model, plus handshake, latency and reset scenarios.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv4, or4, sm4, ir4, ov4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        iv8, or8, sm8, ir8, ov8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .product(p4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8)
    );

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [15:0] ref_mul(int w, logic [31:0] xa, logic [31:0] xb, logic sm);
        longint m  = (longint'(1) << w) - 1;
        longint sa = longint'(xa) & m;
        longint sb = longint'(xb) & m;
        longint pr;
        if (sm && xa[w-1]) sa = sa - (longint'(1) << w);
        if (sm && xb[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        return 16'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic [15:0] prod_of(bit w8);
        return w8 ? p8 : {8'h00, p4};
    endfunction

    function automatic logic ov_of(bit w8);
        return w8 ? ov8 : ov4;
    endfunction

    task automatic drive(input bit w8, input logic [31:0] xa, input logic [31:0] xb,
                         input logic sm, input logic iv);
        if (w8) begin a8 = xa[7:0]; b8 = xb[7:0]; sm8 = sm; iv8 = iv; end
        else    begin a4 = xa[3:0]; b4 = xb[3:0]; sm4 = sm; iv4 = iv; end
    endtask

    // Accept one pair (DUT must be idle), return product and cycles to out_valid.
    task automatic run(input bit w8, input logic [31:0] xa, input logic [31:0] xb,
                       input logic sm, output logic [15:0] p, output int lat);
        drive(w8, xa, xb, sm, 1'b1);
        @(posedge clk); #1;
        drive(w8, xa, xb, sm, 1'b0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ov_of(w8)) begin lat = k; break; end
        end
        p = prod_of(w8);
        if ((w8 ? or8 : or4) && lat > 0) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv4 = 1'b1; a4 = 4'h3; b4 = 4'h3; sm4 = 1'b0; or4 = 1'b1;
        iv8 = 1'b0; a8 = '0;   b8 = '0;   sm8 = 1'b0; or8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 6;
        if (ir4 !== 1'b1)  begin bad++; $display("FAIL reset_ir4 got=%b exp=1", ir4); end
        if (ov4 !== 1'b0)  begin bad++; $display("FAIL reset_ov4 got=%b exp=0", ov4); end
        if (p4 !== 8'h00)  begin bad++; $display("FAIL reset_p4 got=%h exp=00", p4); end
        if (ir8 !== 1'b1)  begin bad++; $display("FAIL reset_ir8 got=%b exp=1", ir8); end
        if (ov8 !== 1'b0)  begin bad++; $display("FAIL reset_ov8 got=%b exp=0", ov8); end
        if (p8 !== 16'h0)  begin bad++; $display("FAIL reset_p8 got=%h exp=0000", p8); end
        iv4 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] p;
        int          lat;
        logic [3:0]  ta [5] = '{4'hF, 4'h8, 4'hD, 4'h8, 4'h0};
        logic [3:0]  tb [5] = '{4'hF, 4'h8, 4'h5, 4'h7, 4'h9};
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  te [5] = '{8'hE1, 8'h40, 8'hF1, 8'hC8, 8'h00};
        for (int i = 0; i < 5; i++) begin
            run(1'b0, 32'(ta[i]), 32'(tb[i]), ts[i], p, lat);
            total += 2;
            if (p[7:0] !== te[i]) begin bad++; $display("FAIL dir4_prod[%0d] got=%h exp=%h", i, p[7:0], te[i]); end
            if (lat != 4)         begin bad++; $display("FAIL dir4_lat[%0d] got=%0d exp=4", i, lat); end
        end
    endtask

    task automatic test_wide;
        logic [15:0] p;
        int          lat;
        run(1'b1, 32'hFF, 32'hFF, 1'b0, p, lat);
        total += 2;
        if (p !== 16'hFE01) begin bad++; $display("FAIL wide_umax got=%h exp=fe01", p); end
        if (lat != 8)       begin bad++; $display("FAIL wide_lat got=%0d exp=8", lat); end
        run(1'b1, 32'h80, 32'h80, 1'b1, p, lat);
        total += 1;
        if (p !== 16'h4000) begin bad++; $display("FAIL wide_smin got=%h exp=4000", p); end
    endtask

    task automatic test_random;
        logic [15:0] p, e;
        int          lat;
        logic [31:0] xa, xb;
        logic        sm;
        for (int i = 0; i < 40; i++) begin
            bit w8 = i[0];
            xa = $urandom; xb = $urandom; sm = 1'($urandom);
            e  = ref_mul(w8 ? 8 : 4, xa, xb, sm);
            run(w8, xa, xb, sm, p, lat);
            total += 2;
            if (p !== e) begin
                bad++;
                $display("FAIL rand_prod w=%0d a=%h b=%h s=%b got=%h exp=%h", w8 ? 8 : 4, xa, xb, sm, p, e);
            end
            if (lat != (w8 ? 8 : 4)) begin bad++; $display("FAIL rand_lat got=%0d exp=%0d", lat, w8 ? 8 : 4); end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] p;
        int          lat;
        or4 = 1'b0;
        run(1'b0, 32'hB, 32'h9, 1'b0, p, lat);
        total += 1;
        if (p[7:0] !== 8'h63) begin bad++; $display("FAIL bp_prod got=%h exp=63", p[7:0]); end
        drive(1'b0, 32'h2, 32'h3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total += 3;
            if (ov4 !== 1'b1)     begin bad++; $display("FAIL bp_ov[%0d] got=%b exp=1", i, ov4); end
            if (p4 !== 8'h63)     begin bad++; $display("FAIL bp_hold[%0d] got=%h exp=63", i, p4); end
            if (ir4 !== 1'b0)     begin bad++; $display("FAIL bp_ir[%0d] got=%b exp=0", i, ir4); end
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk); #1;
        total += 3;
        if (ov4 !== 1'b0)  begin bad++; $display("FAIL bp_release_ov got=%b exp=0", ov4); end
        if (ir4 !== 1'b1)  begin bad++; $display("FAIL bp_release_ir got=%b exp=1", ir4); end
        if (p4 !== 8'h63)  begin bad++; $display("FAIL bp_after_hs got=%h exp=63", p4); end
    endtask

    task automatic test_busy;
        int lat = -1;
        drive(1'b0, 32'hB, 32'h6, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h3, 32'hE, 1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 2) iv4 = 1'b0;
            if (ov4) begin lat = k; break; end
        end
        total += 2;
        if (p4 !== 8'h42) begin bad++; $display("FAIL busy_prod got=%h exp=42", p4); end
        if (lat != 4)     begin bad++; $display("FAIL busy_lat got=%0d exp=4", lat); end
        @(posedge clk); #1;
        total += 1;
        if (ir4 !== 1'b1) begin bad++; $display("FAIL busy_idle got=%b exp=1", ir4); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] p;
        int          lat;
        bit          seen = 1'b0;
        drive(1'b0, 32'h5, 32'h3, 1'b0, 1'b1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total += 3;
        if (ir4 !== 1'b1) begin bad++; $display("FAIL rstmid_ir got=%b exp=1", ir4); end
        if (ov4 !== 1'b0) begin bad++; $display("FAIL rstmid_ov got=%b exp=0", ov4); end
        if (p4 !== 8'h00) begin bad++; $display("FAIL rstmid_prod got=%h exp=00", p4); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen |= ov4;
        end
        total += 1;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_nopulse got=%b exp=0", seen); end
        run(1'b0, 32'h6, 32'h7, 1'b0, p, lat);
        total += 2;
        if (p[7:0] !== 8'h2A) begin bad++; $display("FAIL rstmid_next got=%h exp=2a", p[7:0]); end
        if (lat != 4)         begin bad++; $display("FAIL rstmid_lat got=%0d exp=4", lat); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] expq [$];
        logic [15:0] e;
        logic [31:0] ca, cb;
        logic        csm;
        int          last = -1;
        int          got  = 0;
        bit          acc_now;
        or8 = 1'b1;
        ca = $urandom; cb = $urandom; csm = 1'($urandom);
        drive(1'b1, ca, cb, csm, 1'b1);
        for (int k = 0; k < 200 && got < 5; k++) begin
            acc_now = ir8;
            if (acc_now) expq.push_back(ref_mul(8, ca, cb, csm));
            @(posedge clk); #1;
            if (acc_now) begin
                ca = $urandom; cb = $urandom; csm = 1'($urandom);
                drive(1'b1, ca, cb, csm, 1'b1);
            end
            if (ov8) begin
                got++;
                e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                total += 1;
                if (p8 !== e) begin bad++; $display("FAIL b2b_prod[%0d] got=%h exp=%h", got, p8, e); end
                if (last >= 0) begin
                    total += 1;
                    if (k - last != 10) begin bad++; $display("FAIL b2b_interval got=%0d exp=10", k - last); end
                end
                last = k;
            end
        end
        iv8 = 1'b0;
        total += 1;
        if (got != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", got); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wide();
        test_random();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
